phy_rx_deserializer: RTL and testbench

PHY_RX_DESERIALIZER -- requirements
Module: phy_rx_deserializer

---
 rtl/phy_rx_deserializer.sv | 108 ++++++++++
 tb/tb_phy_rx_deserializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_deserializer.sv
// Serial-to-byte receive deserializer: sliding COMMA search, byte alignment,
// lock after LOCK_COUNT aligned COMMAs, then registered byte presentation.
module phy_rx_deserializer #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter logic [7:0]  IDLE       = 8'h7C,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_16f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out0,
    output logic       valid_out,
    output logic       active,
    output logic       byte_strobe
);

    localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        ST_UNALIGNED,
        ST_ALIGNING,
        ST_ACTIVE
    } state_t;

    state_t             state_q, state_d;
    // Only the seven most recent bits are kept; the eighth is data_in itself.
    logic [6:0]         shreg_q, shreg_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   comma_cnt_q, comma_cnt_d;
    logic [7:0]         data_d;
    logic               valid_d;
    logic               active_d;
    logic               strobe_d;

    logic [7:0]         next_word;
    logic               byte_done;

    assign next_word = {shreg_q, data_in};
    assign byte_done = (bit_cnt_q == 3'd7);

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        shreg_d     = next_word[6:0];
        bit_cnt_d   = bit_cnt_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_out0;
        valid_d     = valid_out;
        active_d    = active;
        strobe_d    = 1'b0;

        case (state_q)
            ST_UNALIGNED: begin
                if (next_word == COMMA) begin
                    bit_cnt_d   = 3'd0;
                    comma_cnt_d = CNT_W'(1);
                    state_d     = ST_ALIGNING;
                end
            end
            ST_ALIGNING: begin
                if (byte_done) begin
                    if (next_word == COMMA) begin
                        comma_cnt_d = comma_cnt_q + CNT_W'(1);
                        if (comma_cnt_d == CNT_W'(LOCK_COUNT)) begin
                            state_d  = ST_ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = ST_UNALIGNED;
                    end
                end
            end
            ST_ACTIVE: begin
                if (byte_done) begin
                    data_d   = next_word;
                    valid_d  = (next_word != COMMA) && (next_word != IDLE);
                    strobe_d = 1'b1;
                end
            end
            default: state_d = ST_UNALIGNED;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_16f) begin
        if (reset) begin
            state_q     <= ST_UNALIGNED;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            data_out0   <= '0;
            valid_out   <= 1'b0;
            active      <= 1'b0;
            byte_strobe <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_out0   <= data_d;
            valid_out   <= valid_d;
            active      <= active_d;
            byte_strobe <= strobe_d;
        end
    end

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Scoreboard bench for phy_rx_deserializer: directed lock scenarios plus
// randomized bit streams against a bit-window reference model.
module tb_phy_rx_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out0;
    logic       valid_out;
    logic       active;
    logic       byte_strobe;

    always #5 clk = ~clk;

    phy_rx_deserializer dut (
        .clk_16f    (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_out0  (data_out0),
        .valid_out  (valid_out),
        .active     (active),
        .byte_strobe(byte_strobe)
    );

    typedef struct {
        logic [7:0] d;
        logic       v;
        int         c;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    bit         exp_act [0:8191];
    bit         exp_rst [0:8191];
    logic [7:0] hold_d;
    logic       hold_v;

    // Reference model: last 8 received bits, search/count/locked mode,
    // and bits elapsed since the aligned byte boundary.
    int win;
    int mode;
    int commas;
    int phase;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_bit(input logic b);
        int   k;
        exp_t e;
        k   = cyc + 1;
        win = (win * 2 + ((b === 1'b1) ? 1 : 0)) % 256;
        if (mode == 0) begin
            if (win == 188) begin
                mode   = 1;
                commas = 1;
                phase  = 0;
            end
        end else begin
            phase++;
            if (phase == 8) begin
                phase = 0;
                if (mode == 1) begin
                    if (win == 188) begin
                        commas++;
                        if (commas == 4) mode = 2;
                    end else begin
                        mode   = 0;
                        commas = 0;
                    end
                end else begin
                    e.d = 8'(win);
                    e.v = (win != 188) && (win != 124);
                    e.c = k;
                    sb.push_back(e);
                end
            end
        end
        if (k < 8192) exp_act[k] = (mode == 2);
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        model_bit(b);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset(input int n);
        int k;
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            data_in = 1'($urandom);
            win = 0; mode = 0; commas = 0; phase = 0;
            k = cyc + 1;
            if (k < 8192) begin
                exp_rst[k] = 1'b1;
                exp_act[k] = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // Monitor: every cycle compare active and held outputs; pop on each strobe.
    initial begin
        hold_d = 8'h00;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < 8192) begin
                if (exp_rst[cyc]) begin
                    hold_d = 8'h00;
                    hold_v = 1'b0;
                end
                while (sb.size() > 0 && sb[0].c < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missed_strobe: got none want byte %h at cycle %0d", sb[0].d, sb[0].c);
                    void'(sb.pop_front());
                end
                chk("active", 8'(active), 8'(exp_act[cyc]));
                if (byte_strobe === 1'b1) begin
                    total++;
                    if (sb.size() == 0 || sb[0].c != cyc) begin
                        bad++;
                        $display("FAIL spurious_strobe: got strobe data %h want no strobe at cycle %0d", data_out0, cyc);
                    end else begin
                        chk("data", data_out0, sb[0].d);
                        chk("valid", 8'(valid_out), 8'(sb[0].v));
                        hold_d = sb[0].d;
                        hold_v = sb[0].v;
                        void'(sb.pop_front());
                    end
                end else begin
                    chk("strobe", 8'(byte_strobe), 8'h00);
                    chk("hold_data", data_out0, hold_d);
                    chk("hold_valid", 8'(valid_out), 8'(hold_v));
                end
            end
        end
    end

    initial begin
        int r;
        reset   = 1'b1;
        data_in = 1'b0;
        win = 0; mode = 0; commas = 0; phase = 0;

        // Reset held with random data.
        do_reset(5);
        chk("rst_data", data_out0, 8'h00);
        chk("rst_active", 8'(active), 8'h00);

        // Aligned lock then payload A5.
        repeat (4) send_byte(8'hBC);
        chk("lock_a5", 8'(active), 8'h01);
        send_byte(8'hA5);
        chk("a5_data", data_out0, 8'hA5);
        chk("a5_valid", 8'(valid_out), 8'h01);
        chk("a5_strobe", 8'(byte_strobe), 8'h01);
        send_bit(1'b0);
        chk("a5_strobe_off", 8'(byte_strobe), 8'h00);
        repeat (6) send_bit(1'b1);
        chk("a5_hold", data_out0, 8'hA5);

        // Lock at a 3-bit offset.
        do_reset(2);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (4) send_byte(8'hBC);
        chk("lock_off3", 8'(active), 8'h01);
        send_byte(8'h3C);
        chk("off3_data", data_out0, 8'h3C);
        chk("off3_valid", 8'(valid_out), 8'h01);

        // Broken COMMA run restarts alignment.
        do_reset(2);
        repeat (3) send_byte(8'hBC);
        send_byte(8'h12);
        chk("broken_run", 8'(active), 8'h00);
        repeat (4) send_byte(8'hBC);
        chk("relock", 8'(active), 8'h01);
        send_byte(8'h55);
        chk("d55_data", data_out0, 8'h55);

        // IDLE and COMMA while locked are presented but not valid.
        send_byte(8'h7C);
        chk("idle_data", data_out0, 8'h7C);
        chk("idle_valid", 8'(valid_out), 8'h00);
        chk("idle_strobe", 8'(byte_strobe), 8'h01);
        send_byte(8'hBC);
        chk("comma_data", data_out0, 8'hBC);
        chk("comma_valid", 8'(valid_out), 8'h00);
        chk("comma_strobe", 8'(byte_strobe), 8'h01);

        // Reset mid-byte while valid payload is held.
        send_byte(8'hA5);
        chk("pre_rst_valid", 8'(valid_out), 8'h01);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        do_reset(1);
        chk("mid_rst_data", data_out0, 8'h00);
        chk("mid_rst_valid", 8'(valid_out), 8'h00);
        chk("mid_rst_active", 8'(active), 8'h00);
        chk("mid_rst_strobe", 8'(byte_strobe), 8'h00);
        repeat (3) send_byte(8'hBC);
        chk("three_bc", 8'(active), 8'h00);
        send_byte(8'hBC);
        chk("four_bc", 8'(active), 8'h01);
        send_byte(8'($urandom));
        send_byte(8'($urandom));

        // Randomized streams: junk bits, COMMA runs, random bytes, rare resets.
        do_reset(1);
        for (int it = 0; it < 60; it++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else if (r < 4) begin
                repeat (int'($urandom_range(1, 7))) send_bit(1'($urandom));
            end else if (r < 8) begin
                repeat (4) send_byte(8'hBC);
            end else if (r == 8) begin
                send_byte(8'h7C);
            end else begin
                send_byte(8'($urandom));
            end
        end

        repeat (10) send_bit(1'b0);
        chk("sb_empty", 8'(sb.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
